mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the 5-stage pipeline, executing the MUL/DIV class of ALU control codes (`0011_x` divide, `0100_x` multiply) that the combinational ALU cannot finish in one cycle. It sits beside the ALU in EX. It accepts one operation via a start pulse, holds busy for a fixed latency, and writes a double-width result into internal HI/LO registers. It is parametrised in operand width, and supports flush and signed/unsigned modes.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; must be even and ≥ 4
- `clk`  in  1  clock; all state changes on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  5  ALU control code:
  - `5'b0011_0` div (signed)
  - `5'b0011_1` divu
  - `5'b0100_0` mult (signed)
  - `5'b0100_1` multu
  - any other code: the request is ignored
- `a`  in  WIDTH  multiplicand / dividend
- `b`  in  WIDTH  multiplier / divisor
- `flush`  in  1  abort the in-flight operation (exception/branch-kill from the pipeline)
- `busy`  out  1  operation in progress; EX stalls while high
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result in this cycle
- `hi`  out  WIDTH  product high half / remainder
- `lo`  out  WIDTH  product low half / quotient

## Operation
- State machine:
  - IDLE → CALC on `start`·valid op·!`flush`.
  - CALC runs `WIDTH` iterations, then → FIX.
  - FIX → DONE.
  - DONE → IDLE.
- Accept (IDLE):
  - latch |a| and |b| (magnitudes for signed ops, raw operands for unsigned);
  - latch the result sign (a[W-1]^b[W-1]) and the remainder sign (a[W-1]);
  - latch the op kind.
- Multiply:
  - radix-2 shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle;
  - FIX negates the 2·WIDTH product when signed and the result sign = 1.
- Divide:
  - restoring, one quotient bit per cycle;
  - FIX negates the quotient when signed and the result sign = 1;
  - FIX negates the remainder when signed and the dividend was negative.
- Divide by zero (no trap):
  - unsigned: `lo` = all-ones, `hi` = `a`;
  - signed: `hi` = `a`, `lo` = 1 if `a`<0 else all-ones.
- Signed overflow MIN/−1: `lo` = MIN, `hi` = 0 (falls out of the magnitude algorithm).
- `hi`/`lo` update only on the DONE transition. They are otherwise held across idle, flush and ignored requests.
- Widths: magnitude of MIN is 2^(W−1), represented unsigned in W bits. All negation is two's-complement mod 2^W (quotient/remainder) or mod 2^(2W) (product).

## Timing
- Reset (`resetn`=0 at an edge): state IDLE, `busy`=0, `done`=0, `hi`=`lo`=0. This applies from any state, mid-operation included.
- Start sampled at edge E0:
  - `busy`=1 from E0 through the edge that enters DONE;
  - `done`=1 and new `hi`/`lo` in the cycle after edge E0+WIDTH+2;
  - `busy`=0 in that same cycle, so back-to-back issue is allowed then.
  - Total latency is WIDTH+2 cycles; for WIDTH=32, `done` appears 34 cycles after start.
- `start` while `busy`=1: ignored, with no queueing.
- `flush`:
  - at any edge in CALC/FIX: → IDLE next cycle, `busy`=0, no `done`, `hi`/`lo` unchanged;
  - together with `start` in IDLE: flush wins and the request is dropped.
- `flush` in the DONE cycle has no effect; the result is already committed.
- `start` with an invalid `op`: no state change, `busy` stays 0.
- `done` is registered and never asserted for two consecutive cycles.

## Structure
- Shared package `mdu_pkg`:
  - ALU control-code localparams `ALU_DIV`, `ALU_DIVU`, `ALU_MULT`, `ALU_MULTU`, the same values as the ALU decoder emits;
  - state enum `mdu_state_t` {IDLE, CALC, FIX, DONE};
  - the ALU decoder imports the same code constants.
- Single module. Multiply and divide share the 2·WIDTH shift register and the iteration counter ($clog2(WIDTH)+1 bits); no sub-module is needed.

## Test plan
(WIDTH=32)
- multu 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 34 cycles after start, `busy` high for the cycles in between.
- mult −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; then immediate back-to-back mult 0 × 0x12345678 → `hi`=`lo`=0.
- div −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; divu 7 / 0 → `lo`=0xFFFFFFFF, `hi`=7; div −5 / 0 → `lo`=1, `hi`=0xFFFFFFFB.
- div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Flush 10 cycles into a divu → `busy`=0 next cycle, no `done`, `hi`/`lo` keep prior values. `start` asserted while busy → ignored, and `done` arrives at the original time.
- `start` with `op`=5'b0000_0 → `busy` stays 0. `resetn` low mid-CALC → next cycle `busy`=0, `hi`=`lo`=0, no `done`.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: ALU control codes, op decode helpers and FSM states shared by the ALU decoder and mdu_iter
package mdu_pkg;

   localparam logic [4:0] ALU_DIV   = 5'b0011_0;
   localparam logic [4:0] ALU_DIVU  = 5'b0011_1;
   localparam logic [4:0] ALU_MULT  = 5'b0100_0;
   localparam logic [4:0] ALU_MULTU = 5'b0100_1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

   function automatic logic op_valid(input logic [4:0] op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_MULT, ALU_MULTU};
   endfunction

   function automatic logic op_is_div(input logic [4:0] op);
      return op[4:1] == 4'b0011;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply / restoring divide unit with HI/LO result registers
//   clk, resetn (sync, active-low)
//   start, op, a, b : request (taken only in IDLE with a valid op and no flush)
//   flush           : abort an operation in CALC/FIX
//   busy, done      : in-progress flag, one-cycle result pulse
//   hi, lo          : product high/low, or remainder/quotient
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   mdu_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q, mul_step, div_step, fix_val;
   logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, mag_a, mag_b;
   logic [WIDTH:0]     add_sum, div_diff;
   logic               div_q, neg_q, rneg_q, done_q, accept, sgn, last;

   always_comb begin
      sgn      = !op[0];
      accept   = state_q == IDLE && start && op_valid(op) && !flush;
      last     = cnt_q == CW'(WIDTH - 1);
      mag_a    = sgn && a[WIDTH-1] ? -a : a;
      mag_b    = sgn && b[WIDTH-1] ? -b : b;
      // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mul_step = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      // Divide: acc = {remainder, dividend bits / quotient bits}, shifted left each step
      div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
      div_step = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      fix_val  = div_q ? {rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH],
                          neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]}
                       : (neg_q ? -acc_q : acc_q);
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = accept ? CALC : IDLE;
         CALC: state_d = flush ? IDLE : (last ? FIX : CALC);
         FIX:  state_d = flush ? IDLE : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = state_q != IDLE;
      done = done_q;
      hi   = hi_q;
      lo   = lo_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= state_q == DONE;
         if (state_q == DONE) {hi_q, lo_q} <= acc_q;
         if (accept) begin
            cnt_q  <= '0;
            div_q  <= op_is_div(op);
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= sgn && a[WIDTH-1];
            opnd_q <= op_is_div(op) ? mag_b : mag_a;
            acc_q  <= {{WIDTH{1'b0}}, op_is_div(op) ? mag_a : mag_b};
         end
         if (state_q == CALC) begin
            acc_q <= div_q ? div_step : mul_step;
            cnt_q <= cnt_q + CW'(1);
         end
         if (state_q == FIX) acc_q <= fix_val;
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against an arithmetic reference model
module tb_mdu_iter;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0, busy, done;
   logic [4:0]   op = ALU_MULTU;
   logic [W-1:0] a = '0, b = '0, hi, lo;
   logic [W-1:0] exp_hi = '0, exp_lo = '0;
   logic [4:0]   ops [4] = '{ALU_DIV, ALU_DIVU, ALU_MULT, ALU_MULTU};
   int           checks = 0, failures = 0;

   mdu_iter #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic void model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
      longint      p;
      logic [63:0] u;
      case (o)
         ALU_MULT: begin
            p = longint'($signed(x)) * longint'($signed(y));
            {h, l} = p;
         end
         ALU_MULTU: begin
            u = {32'b0, x} * {32'b0, y};
            {h, l} = u;
         end
         ALU_DIVU: begin
            if (y == 0) begin h = x; l = '1; end
            else begin h = x % y; l = x / y; end
         end
         default: begin
            if (y == 0) begin h = x; l = x[W-1] ? 32'd1 : 32'hFFFF_FFFF; end
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin h = '0; l = x; end
            else begin h = $signed(x) % $signed(y); l = $signed(x) / $signed(y); end
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   // Called at a negedge; mode 1 pokes start mid-operation, mode 2 flushes in the DONE-state cycle
   task automatic run(input string tag, input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] eh, input logic [W-1:0] el, input int mode);
      int k;
      bit got, busy_ok;
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; got = 1'b0; busy_ok = busy;
      while (k < 40 && !got) begin
         if (mode == 1) begin start = (k == 5); op = ALU_DIVU; a = 1; b = 1; end
         flush = (mode == 2) && (k == 33);
         @(negedge clk);
         k++;
         if (done) got = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
      start = 1'b0; flush = 1'b0;
      check({tag, " latency"}, 64'(k), 64'd34);
      check({tag, " busy_between"}, 64'(busy_ok), 64'd1);
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(eh));
      check({tag, " lo"}, 64'(lo), 64'(el));
      exp_hi = eh; exp_lo = el;
   endtask

   initial begin
      logic [4:0]   o;
      logic [W-1:0] x, y, h, l;
      bit           seen;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      run("multu_max", ALU_MULTU, '1, '1, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      run("mult_neg", ALU_MULT, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
      run("mult_zero_b2b", ALU_MULT, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 0);
      run("div_neg", ALU_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run("divu_zero", ALU_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 0);
      run("div_zero_neg", ALU_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'd1, 0);
      run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
      @(negedge clk);
      check("done_single_cycle", 64'(done), 64'd0);
      for (int i = 0; i < 24; i++) begin
         o = ops[$urandom_range(0, 3)];
         x = pick();
         y = pick();
         model(o, x, y, h, l);
         run($sformatf("rand%0d op=%b a=%h b=%h", i, o, x, y), o, x, y, h, l, 0);
      end
      x = W'($urandom); y = W'($urandom);
      model(ALU_MULT, x, y, h, l);
      run("start_while_busy", ALU_MULT, x, y, h, l, 1);
      @(negedge clk);
      check("no_queued_op busy", 64'(busy), 64'd0);
      check("no_queued_op done", 64'(done), 64'd0);
      x = W'($urandom); y = W'($urandom_range(1, 1000));
      model(ALU_DIV, x, y, h, l);
      run("flush_in_done", ALU_DIV, x, y, h, l, 2);
      op = ALU_DIVU; a = 32'd100; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("flush no_done", 64'(seen), 64'd0);
      check("flush hi_held", 64'(hi), 64'(exp_hi));
      check("flush lo_held", 64'(lo), 64'(exp_lo));
      op = 5'b0000_0; a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("invalid_op busy", 64'(busy), 64'd0);
      check("invalid_op hi_held", 64'(hi), 64'(exp_hi));
      op = ALU_MULT; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("start_with_flush busy", 64'(busy), 64'd0);
      op = ALU_MULTU; a = 32'd12345; b = 32'd678; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_calc busy", 64'(busy), 64'd1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("mid_reset busy", 64'(busy), 64'd0);
      check("mid_reset done", 64'(done), 64'd0);
      check("mid_reset hi", 64'(hi), 64'd0);
      check("mid_reset lo", 64'(lo), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("mid_reset no_done", 64'(seen), 64'd0);
      x = pick(); y = pick();
      model(ALU_DIVU, x, y, h, l);
      run("after_reset divu", ALU_DIVU, x, y, h, l, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
